// File: rtl/snn_spike_classifier.sv
// Spike-count classifier: counts per-neuron spikes over a timestep budget while
// enabling the LIF array, then argmax-scans the counts and offers the winner on valid/ready.

module snn_spike_lane #(
  parameter int CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr_i,
  input  logic                 inc_i,
  output logic [CNT_WIDTH-1:0] cnt_o
);
  logic [CNT_WIDTH-1:0] cnt_q;

  // Saturating counter: sticks at all-ones instead of wrapping.
  always_ff @(posedge clk) begin
    if (rst || clr_i)
      cnt_q <= '0;
    else if (inc_i && (cnt_q != '1))
      cnt_q <= cnt_q + 1'b1;
  end

  assign cnt_o = cnt_q;
endmodule

module snn_spike_classifier #(
  parameter int NUM_NEURONS = 10,
  parameter int CNT_WIDTH   = 8,
  parameter int STEP_WIDTH  = 16,
  parameter int IDX_WIDTH   = $clog2(NUM_NEURONS)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   abort,
  input  logic [STEP_WIDTH-1:0]  num_steps,
  input  logic [NUM_NEURONS-1:0] fired_flags_in,
  input  logic [NUM_NEURONS-1:0] valid_flags_in,
  output logic [NUM_NEURONS-1:0] enables_out,
  output logic                   busy,
  output logic                   class_valid,
  input  logic                   class_ready,
  output logic [IDX_WIDTH-1:0]   class_id,
  output logic [CNT_WIDTH-1:0]   class_count,
  output logic                   class_tie
);
  typedef enum logic [1:0] {IDLE, RUN, SCAN, HOLD} state_t;

  localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NUM_NEURONS - 1);

  state_t                  state_q;
  logic [STEP_WIDTH-1:0]   steps_q, step_q;
  logic [IDX_WIDTH-1:0]    scan_idx_q;
  logic [CNT_WIDTH-1:0]    max_q, max_d;
  logic [IDX_WIDTH-1:0]    id_q, id_d;
  logic                    tie_q, tie_d;
  logic [IDX_WIDTH-1:0]    class_id_q;
  logic [CNT_WIDTH-1:0]    class_count_q;
  logic                    class_tie_q;

  logic [NUM_NEURONS-1:0][CNT_WIDTH-1:0] cnt;
  logic [CNT_WIDTH-1:0]    cur_cnt;
  logic                    run_act, step_done, last_step, clr;

  assign clr       = (state_q == IDLE) && start;
  assign run_act   = (state_q == RUN) && !abort;
  assign step_done = run_act && (&valid_flags_in);
  // steps_q is nonzero whenever RUN is entered, so the decrement cannot wrap.
  assign last_step = step_done && (step_q == steps_q - 1'b1);

  for (genvar g = 0; g < NUM_NEURONS; g++) begin : g_lane
    snn_spike_lane #(.CNT_WIDTH(CNT_WIDTH)) u_lane (
      .clk   (clk),
      .rst   (rst),
      .clr_i (clr),
      .inc_i (run_act && valid_flags_in[g] && fired_flags_in[g]),
      .cnt_o (cnt[g])
    );
  end

  // Index 0 seeds the running max; later entries replace it only when strictly
  // greater, so the lowest index wins ties.
  always_comb begin
    cur_cnt = cnt[scan_idx_q];
    max_d   = max_q;
    id_d    = id_q;
    tie_d   = tie_q;
    if (scan_idx_q == '0) begin
      max_d = cur_cnt;
      id_d  = '0;
      tie_d = 1'b0;
    end else if (cur_cnt > max_q) begin
      max_d = cur_cnt;
      id_d  = scan_idx_q;
      tie_d = 1'b0;
    end else if (cur_cnt == max_q) begin
      tie_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      steps_q       <= '0;
      step_q        <= '0;
      scan_idx_q    <= '0;
      max_q         <= '0;
      id_q          <= '0;
      tie_q         <= 1'b0;
      class_id_q    <= '0;
      class_count_q <= '0;
      class_tie_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            steps_q    <= num_steps;
            step_q     <= '0;
            scan_idx_q <= '0;
            state_q    <= (num_steps == '0) ? SCAN : RUN;
          end
        end
        RUN: begin
          if (abort) begin
            state_q <= IDLE;
          end else if (step_done) begin
            step_q <= step_q + 1'b1;
            if (last_step) state_q <= SCAN;
          end
        end
        SCAN: begin
          if (abort) begin
            state_q <= IDLE;
          end else begin
            max_q <= max_d;
            id_q  <= id_d;
            tie_q <= tie_d;
            if (scan_idx_q == LAST_IDX) begin
              class_id_q    <= id_d;
              class_count_q <= max_d;
              class_tie_q   <= tie_d;
              state_q       <= HOLD;
            end else begin
              scan_idx_q <= scan_idx_q + 1'b1;
            end
          end
        end
        HOLD: begin
          if (class_ready) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign enables_out = {NUM_NEURONS{state_q == RUN}};
  assign busy        = (state_q != IDLE);
  assign class_valid = (state_q == HOLD);
  assign class_id    = class_id_q;
  assign class_count = class_count_q;
  assign class_tie   = class_tie_q;
endmodule
